// File: rtl/dsk_sector_server_pkg.sv
// Shared types and constants for the DSK sector server (SDRAM-backed wd1793 sector responder).
package dsk_server_pkg;

  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_WAIT, RD_LO, RD_HI,
    WR_SETUP, WR_LO, WR_HI, WR_REQ, WR_WAIT, DONE
  } state_e;

  localparam int SECTOR_BYTES     = 512;
  localparam int WORDS_PER_SECTOR = 256;
  localparam logic [23:0] DEF_IMG_BASE = 24'h100000;

  // (lba+1)*512 <= size  <=>  lba+1 <= size/512; 33 bits so lba = 2^32-1 cannot wrap
  function automatic logic lba_in_range(input logic [31:0] lba, input logic [31:0] size);
    return ({1'b0, lba} + 33'd1) <= {10'd0, size[31:9]};
  endfunction

endpackage

// File: rtl/dsk_sector_server_if.sv
// Sector buffer bus between the wd1793 initiator (master) and the sector server (slave).
interface dsk_sector_server_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  modport master (output sd_lba, sd_rd, sd_wr, sd_buff_din,
                  input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr);
  modport slave  (input  sd_lba, sd_rd, sd_wr, sd_buff_din,
                  output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr);
endinterface

// File: rtl/dsk_sector_server_toggle_req_port.sv
// Toggle req/ack SDRAM port: one outstanding request, busy while req differs from ack.
module toggle_req_port (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic mem_ack,
  output logic mem_req,
  output logic busy
);
  logic mem_req_q, mem_req_d;

  always_comb mem_req_d = start ? ~mem_req_q : mem_req_q;

  // Reset adopts the current ack so the SDRAM side never sees a phantom request.
  always_ff @(posedge clk) begin
    if (!reset_n) mem_req_q <= mem_ack;
    else          mem_req_q <= mem_req_d;
  end

  assign mem_req = mem_req_q;
  assign busy    = mem_req_q ^ mem_ack;
endmodule

// File: rtl/dsk_sector_server.sv
// Serves 512-byte DSK sectors from an SDRAM-resident image over the sd_* sector bus.
// Optional DSK_SERVER_WP_EN adds a wp input that suppresses SDRAM writes.
module dsk_sector_server
  import dsk_server_pkg::*;
#(
  parameter int               ADDR_W   = 24,
  parameter logic [ADDR_W-1:0] IMG_BASE = ADDR_W'(DEF_IMG_BASE)
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              img_mounted,
  input  logic [31:0]       img_size,
  dsk_sector_server_if.slave sd,
`ifdef DSK_SERVER_WP_EN
  input  logic              wp,
`endif
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [1:0]        mem_ds,
  output logic [15:0]       mem_d,
  input  logic [15:0]       mem_q
);
  state_e            state_q, state_d;
  logic [31:0]       size_q, size_d;
  logic [31:0]       lba_q, lba_d;
  logic              range_q, range_d;
  logic [7:0]        k_q, k_d;
  logic [7:0]        byte_q, byte_d;
  logic              ack_q, ack_d;
  logic [8:0]        baddr_q, baddr_d;
  logic [7:0]        bdout_q, bdout_d;
  logic              bwr_q, bwr_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              mem_we_q, mem_we_d;
  logic [15:0]       mem_d_q, mem_d_d;
  logic              start, busy, wp_i;
  logic [ADDR_W-1:0] word_addr;

`ifdef DSK_SERVER_WP_EN
  assign wp_i = wp;
`else
  assign wp_i = 1'b0;
`endif

  toggle_req_port u_port (
    .clk(clk_sys), .reset_n(reset_n), .start(start),
    .mem_ack(mem_ack), .mem_req(mem_req), .busy(busy)
  );

  assign word_addr = ADDR_W'(40'(IMG_BASE) + {lba_q, 8'h00} + 40'(k_q));

  always_comb begin
    state_d  = state_q;
    size_d   = img_mounted ? img_size : size_q;
    lba_d    = lba_q;
    range_d  = range_q;
    k_d      = k_q;
    byte_d   = byte_q;
    ack_d    = ack_q;
    baddr_d  = baddr_q;
    bdout_d  = bdout_q;
    bwr_d    = 1'b0;
    mem_a_d  = mem_a_q;
    mem_we_d = mem_we_q;
    mem_d_d  = mem_d_q;
    start    = 1'b0;
    case (state_q)
      IDLE: if (sd.sd_rd || sd.sd_wr) begin
        lba_d   = sd.sd_lba;
        // range flag doubles as "touch SDRAM": a protected write never does
        range_d = lba_in_range(sd.sd_lba, size_q) && (sd.sd_rd || !wp_i);
        k_d     = 8'd0;
        ack_d   = 1'b1;
        baddr_d = 9'd0;
        state_d = sd.sd_rd ? RD_REQ : WR_SETUP;
      end
      RD_REQ: if (range_q) begin
        start    = 1'b1;
        mem_a_d  = word_addr;
        mem_we_d = 1'b0;
        state_d  = RD_WAIT;
      end else begin
        bwr_d   = 1'b1;
        baddr_d = {k_q, 1'b0};
        bdout_d = 8'h00;
        byte_d  = 8'h00;
        state_d = RD_LO;
      end
      RD_WAIT: if (!busy) begin
        bwr_d   = 1'b1;
        baddr_d = {k_q, 1'b0};
        bdout_d = mem_q[7:0];
        byte_d  = mem_q[15:8];
        state_d = RD_LO;
      end
      RD_LO: begin
        bwr_d   = 1'b1;
        baddr_d = {k_q, 1'b1};
        bdout_d = byte_q;
        state_d = RD_HI;
      end
      RD_HI: if (k_q == 8'hFF) begin
        ack_d   = 1'b0;
        state_d = DONE;
      end else begin
        k_d     = k_q + 8'd1;
        state_d = RD_REQ;
      end
      // Odd address goes out while the even byte is still in flight on sd_buff_din.
      WR_SETUP: begin
        baddr_d = {k_q, 1'b1};
        state_d = WR_LO;
      end
      WR_LO: begin
        byte_d  = sd.sd_buff_din;
        state_d = WR_HI;
      end
      WR_HI: if (range_q) begin
        mem_a_d  = word_addr;
        mem_d_d  = {sd.sd_buff_din, byte_q};
        mem_we_d = 1'b1;
        state_d  = WR_REQ;
      end else if (k_q == 8'hFF) begin
        ack_d   = 1'b0;
        state_d = DONE;
      end else begin
        k_d     = k_q + 8'd1;
        baddr_d = {k_q + 8'd1, 1'b0};
        state_d = WR_SETUP;
      end
      WR_REQ: begin
        start   = 1'b1;
        state_d = WR_WAIT;
      end
      WR_WAIT: if (!busy) begin
        mem_we_d = 1'b0;
        if (k_q == 8'hFF) begin
          ack_d   = 1'b0;
          state_d = DONE;
        end else begin
          k_d     = k_q + 8'd1;
          baddr_d = {k_q + 8'd1, 1'b0};
          state_d = WR_SETUP;
        end
      end
      DONE: if (!sd.sd_rd && !sd.sd_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      size_q   <= 32'd0;
      lba_q    <= 32'd0;
      range_q  <= 1'b0;
      k_q      <= 8'd0;
      byte_q   <= 8'd0;
      ack_q    <= 1'b0;
      baddr_q  <= 9'd0;
      bdout_q  <= 8'd0;
      bwr_q    <= 1'b0;
      mem_a_q  <= '0;
      mem_we_q <= 1'b0;
      mem_d_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      lba_q    <= lba_d;
      range_q  <= range_d;
      k_q      <= k_d;
      byte_q   <= byte_d;
      ack_q    <= ack_d;
      baddr_q  <= baddr_d;
      bdout_q  <= bdout_d;
      bwr_q    <= bwr_d;
      mem_a_q  <= mem_a_d;
      mem_we_q <= mem_we_d;
      mem_d_q  <= mem_d_d;
    end
  end

  assign sd.sd_ack       = ack_q;
  assign sd.sd_buff_addr = baddr_q;
  assign sd.sd_buff_dout = bdout_q;
  assign sd.sd_buff_wr   = bwr_q;
  assign mem_a           = mem_a_q;
  assign mem_we          = mem_we_q;
  assign mem_d           = mem_d_q;
  assign mem_ds          = 2'b11;
endmodule

// File: tb/tb_dsk_sector_server.sv
// Directed bench for dsk_sector_server with an SDRAM toggle-port model and a sector buffer model.
module tb_dsk_sector_server;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        img_mounted = 1'b0;
  logic [31:0] img_size = 32'd0;
  logic        mem_req, mem_we;
  logic        mem_ack = 1'b0;
  logic [23:0] mem_a;
  logic [1:0]  mem_ds;
  logic [15:0] mem_d;
  logic [15:0] mem_q = 16'd0;
`ifdef DSK_SERVER_WP_EN
  logic        wp = 1'b0;
`endif

  dsk_sector_server_if sd_if();

  always #5 clk_sys = ~clk_sys;

  dsk_sector_server dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .img_mounted(img_mounted), .img_size(img_size),
    .sd(sd_if),
`ifdef DSK_SERVER_WP_EN
    .wp(wp),
`endif
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a), .mem_we(mem_we),
    .mem_ds(mem_ds), .mem_d(mem_d), .mem_q(mem_q)
  );

  // SDRAM model: 2-cycle turnaround; read data = byte n of a sector holds n[7:0]
  int          lat_cnt = 0;
  logic [23:0] rd_log[$];
  logic [23:0] wa_log[$];
  logic [15:0] wd_log[$];
  logic [1:0]  ds_log[$];
  always @(posedge clk_sys) begin
    if (mem_req != mem_ack) begin
      if (lat_cnt == 2) begin
        lat_cnt <= 0;
        mem_ack <= mem_req;
        if (mem_we) begin
          wa_log.push_back(mem_a); wd_log.push_back(mem_d); ds_log.push_back(mem_ds);
        end else begin
          rd_log.push_back(mem_a);
          mem_q <= {8'(2 * mem_a[7:0] + 1), 8'(2 * mem_a[7:0])};
        end
      end else lat_cnt <= lat_cnt + 1;
    end else lat_cnt <= 0;
  end

  // Sector buffer model: byte n = n ^ 0x5A, one cycle behind the address
  always @(posedge clk_sys) sd_if.sd_buff_din <= sd_if.sd_buff_addr[7:0] ^ 8'h5A;

  int   cyc = 0, strobe_cnt = 0, tog_cnt = 0, rise_cnt = 0, we_cnt = 0;
  int   last_strobe_cyc = 0, ack_fall_cyc = 0, epoch = 0;
  logic [7:0] rbuf[512];
  int   rb_ep[512], ad_ep[512];
  logic ack_prev = 1'b0, req_prev = 1'b0;
  always @(negedge clk_sys) begin
    cyc++;
    if (sd_if.sd_buff_wr) begin
      strobe_cnt++;
      rbuf[sd_if.sd_buff_addr]  = sd_if.sd_buff_dout;
      rb_ep[sd_if.sd_buff_addr] = epoch;
      last_strobe_cyc = cyc;
    end
    if (sd_if.sd_ack) ad_ep[sd_if.sd_buff_addr] = epoch;
    if (sd_if.sd_ack && !ack_prev) rise_cnt++;
    if (!sd_if.sd_ack && ack_prev) ack_fall_cyc = cyc;
    if (mem_req !== req_prev) tog_cnt++;
    if (mem_we) we_cnt++;
    ack_prev = sd_if.sd_ack;
    req_prev = mem_req;
  end

  int n_chk = 0, n_err = 0;
  int s_strobe, s_tog, s_rise, s_we, s_rd, s_wr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic snap();
    epoch++;
    s_strobe = strobe_cnt; s_tog = tog_cnt; s_rise = rise_cnt; s_we = we_cnt;
    s_rd = rd_log.size(); s_wr = wa_log.size();
  endtask

  // Raise the request, wait (bounded) for sd_ack to rise and fall; request is left held.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] lba, output int ok);
    @(negedge clk_sys);
    snap();
    sd_if.sd_lba = lba; sd_if.sd_rd = rd; sd_if.sd_wr = wr;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (sd_if.sd_ack) begin ok = 1; break; end
    end
    if (ok == 1) begin
      ok = 0;
      for (int i = 0; i < 8000; i++) begin
        @(negedge clk_sys);
        if (!sd_if.sd_ack) begin ok = 1; break; end
      end
    end
    @(negedge clk_sys);
  endtask

  task automatic drop();
    sd_if.sd_rd = 1'b0; sd_if.sd_wr = 1'b0;
    @(negedge clk_sys);
  endtask

  // Count bytes of the latest transfer that were not strobed or differ from the pattern.
  function automatic int bad_bytes(input logic zero);
    int bad = 0;
    for (int i = 0; i < 512; i++)
      if (rb_ep[i] != epoch || rbuf[i] !== (zero ? 8'h00 : 8'(i))) bad++;
    return bad;
  endfunction

  function automatic int unseen_addrs();
    int bad = 0;
    for (int i = 0; i < 512; i++) if (ad_ep[i] != epoch) bad++;
    return bad;
  endfunction

  initial begin
    int ok, bad;
    sd_if.sd_lba = 32'd0; sd_if.sd_rd = 1'b0; sd_if.sd_wr = 1'b0;
    for (int i = 0; i < 512; i++) begin rb_ep[i] = 0; ad_ep[i] = 0; end
    repeat (3) @(negedge clk_sys);
    chk("rst_ack", 32'(sd_if.sd_ack), 32'd0);
    chk("rst_bwr", 32'(sd_if.sd_buff_wr), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_baddr", 32'(sd_if.sd_buff_addr), 32'd0);
    chk("rst_dout", 32'(sd_if.sd_buff_dout), 32'd0);
    chk("rst_mem_a", 32'(mem_a), 32'd0);
    chk("rst_mem_d", 32'(mem_d), 32'd0);
    chk("rst_req_eq_ack", 32'(mem_req == mem_ack), 32'd1);
    reset_n = 1'b1;

    // No image mounted yet: everything is out of range
    xfer(1'b1, 1'b0, 32'd0, ok); drop();
    chk("nomnt_done", ok, 1);
    chk("nomnt_toggles", tog_cnt - s_tog, 0);
    chk("nomnt_bytes_bad", bad_bytes(1'b1), 0);

    @(negedge clk_sys); img_mounted = 1'b1; img_size = 32'h1000;
    @(negedge clk_sys); img_mounted = 1'b0; img_size = 32'd0;

    xfer(1'b1, 1'b0, 32'd2, ok); drop();
    chk("rd2_done", ok, 1);
    chk("rd2_strobes", strobe_cnt - s_strobe, 512);
    chk("rd2_sdram_reads", rd_log.size() - s_rd, 256);
    chk("rd2_first_addr", 32'(rd_log[s_rd]), 32'h100200);
    chk("rd2_last_addr", 32'(rd_log[rd_log.size() - 1]), 32'h1002FF);
    chk("rd2_byte0", 32'(rbuf[0]), 32'h00);
    chk("rd2_byte1", 32'(rbuf[1]), 32'h01);
    chk("rd2_byte511", 32'(rbuf[511]), 32'hFF);
    chk("rd2_bytes_bad", bad_bytes(1'b0), 0);
    chk("rd2_ack_after_last", ack_fall_cyc - last_strobe_cyc, 1);
    chk("rd2_ack_rises", rise_cnt - s_rise, 1);

    xfer(1'b0, 1'b1, 32'd1, ok); drop();
    chk("wr1_done", ok, 1);
    chk("wr1_writes", wa_log.size() - s_wr, 256);
    chk("wr1_first_addr", 32'(wa_log[s_wr]), 32'h100100);
    chk("wr1_first_data", 32'(wd_log[s_wr]), 32'h5B5A);
    chk("wr1_ds", 32'(ds_log[s_wr]), 32'h3);
    bad = 0;
    for (int k = 0; k < 256 && s_wr + k < wa_log.size(); k++)
      if (wa_log[s_wr + k] != 24'h100100 + 24'(k) ||
          wd_log[s_wr + k] != {8'(2 * k + 1) ^ 8'h5A, 8'(2 * k) ^ 8'h5A}) bad++;
    chk("wr1_words_bad", bad, 0);
    chk("wr1_addrs_unseen", unseen_addrs(), 0);
    chk("wr1_no_reads", rd_log.size() - s_rd, 0);

    // lba 8 is one past the end of a 0x1000 image; lba 7 is the last valid sector
    xfer(1'b1, 1'b0, 32'd8, ok); drop();
    chk("oor_done", ok, 1);
    chk("oor_toggles", tog_cnt - s_tog, 0);
    chk("oor_strobes", strobe_cnt - s_strobe, 512);
    chk("oor_bytes_bad", bad_bytes(1'b1), 0);
    chk("oor_ack_rises", rise_cnt - s_rise, 1);

    xfer(1'b1, 1'b0, 32'd7, ok); drop();
    chk("lba7_reads", rd_log.size() - s_rd, 256);
    chk("lba7_last_addr", 32'(rd_log[rd_log.size() - 1]), 32'h1007FF);

    // Both requests high: read wins; then hold sd_rd long after completion
    xfer(1'b1, 1'b1, 32'd3, ok);
    chk("both_done", ok, 1);
    chk("both_strobes", strobe_cnt - s_strobe, 512);
    chk("both_no_writes", wa_log.size() - s_wr, 0);
    sd_if.sd_wr = 1'b0;
    repeat (20) @(negedge clk_sys);
    chk("hold_no_rerun", rise_cnt - s_rise, 1);
    chk("hold_ack_low", 32'(sd_if.sd_ack), 32'd0);
    drop();
    repeat (3) @(negedge clk_sys);
    chk("drop_ack_low", 32'(sd_if.sd_ack), 32'd0);

    // Reset in the middle of a read
    @(negedge clk_sys);
    snap();
    sd_if.sd_lba = 32'd2; sd_if.sd_rd = 1'b1;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      if (strobe_cnt - s_strobe >= 100) begin ok = 1; break; end
    end
    chk("mid_reached_100", ok, 1);
    reset_n = 1'b0; sd_if.sd_rd = 1'b0;
    @(posedge clk_sys); #1;
    chk("mid_rst_ack", 32'(sd_if.sd_ack), 32'd0);
    chk("mid_rst_req_eq_ack", 32'(mem_req == mem_ack), 32'd1);
    chk("mid_rst_bwr", 32'(sd_if.sd_buff_wr), 32'd0);
    @(negedge clk_sys); reset_n = 1'b1;
    @(negedge clk_sys); img_mounted = 1'b1; img_size = 32'h1000;
    @(negedge clk_sys); img_mounted = 1'b0;

    xfer(1'b1, 1'b0, 32'd5, ok); drop();
    chk("post_rst_done", ok, 1);
    chk("post_rst_strobes", strobe_cnt - s_strobe, 512);
    chk("post_rst_first_addr", 32'(rd_log[s_rd]), 32'h100500);
    chk("post_rst_bytes_bad", bad_bytes(1'b0), 0);

`ifdef DSK_SERVER_WP_EN
    wp = 1'b1;
    xfer(1'b0, 1'b1, 32'd0, ok); drop();
    wp = 1'b0;
    chk("wp_done", ok, 1);
    chk("wp_we_cycles", we_cnt - s_we, 0);
    chk("wp_writes", wa_log.size() - s_wr, 0);
    chk("wp_addrs_unseen", unseen_addrs(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
